// File: rtl/dmem_arbiter.sv
// Round-robin two-master arbiter and access sequencer in front of the word-addressed
// DataMemory; one memory access per grant with registered strobes, read data and ack.
module dmem_arbiter #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [29:0] WORD_LIMIT = 30'(DEPTH);

    state_t            state;
    logic              last_grant;
    logic              cur_id;
    logic              cur_we;
    logic              cur_err;

    logic              elig0;
    logic              elig1;
    logic              grant_valid;
    logic              grant_id;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;
    logic [DATA_W-1:0] resp_rdata;

    // The master currently being acknowledged is masked so the other one gets the next slot.
    always_comb begin
        elig0       = m0_req && !((state == RESP) && (cur_id == 1'b0));
        elig1       = m1_req && !((state == RESP) && (cur_id == 1'b1));
        grant_valid = elig0 || elig1;
        if (elig0 && elig1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = elig1;
        end
        sel_we    = grant_id ? m1_we    : m0_we;
        sel_addr  = grant_id ? m1_addr  : m0_addr;
        sel_wdata = grant_id ? m1_wdata : m0_wdata;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= WORD_LIMIT);
    end

    assign resp_rdata = (cur_we || cur_err) ? '0 : mem_rdata;

    // Strobes and responses are single-cycle pulses, so every output defaults to 0 each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            cur_we     <= 1'b0;
            cur_err    <= 1'b0;
            m0_ack     <= 1'b0;
            m0_rdata   <= '0;
            m0_err     <= 1'b0;
            m1_ack     <= 1'b0;
            m1_rdata   <= '0;
            m1_err     <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            m0_ack    <= 1'b0;
            m0_rdata  <= '0;
            m0_err    <= 1'b0;
            m1_ack    <= 1'b0;
            m1_rdata  <= '0;
            m1_err    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (state)
                IDLE, RESP: begin
                    if (grant_valid) begin
                        state      <= ACCESS;
                        cur_id     <= grant_id;
                        last_grant <= grant_id;
                        cur_we     <= sel_we;
                        cur_err    <= sel_err;
                        mem_read   <= !sel_we && !sel_err;
                        mem_write  <= sel_we && !sel_err;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (cur_id) begin
                        m1_ack   <= 1'b1;
                        m1_err   <= cur_err;
                        m1_rdata <= resp_rdata;
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_err   <= cur_err;
                        m0_rdata <= resp_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 256-word DataMemory model;
// directed vectors push expected responses, a negedge monitor pops and compares them.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          ack_ids[$];
    int          ack_cycles[$];
    int          tests    = 0;
    int          failures = 0;
    int          cycle    = 0;
    int          ack_cnt0 = 0;
    int          ack_cnt1 = 0;
    int          wr_cnt   = 0;
    int          rd_cnt   = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [31:0] mem_model [256];
    logic        mem_init = 1'b0;

    dmem_arbiter #(.DEPTH(256), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Word i is preloaded with 0x1000_0000 + i so read data is easy to predict by hand.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= 32'h1000_0000 + 32'(i);
            mem_init <= 1'b1;
        end else if (mem_write) begin
            mem_model[mem_addr[9:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = mem_model[mem_addr[9:2]];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic flag_unexpected(input string name);
        tests++;
        failures++;
        $display("[TB] FAIL %s: got ack, expected none", name);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mem_write) begin
            wr_cnt++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
        end
        if (mem_read) rd_cnt++;
        if (m0_ack) begin
            ack_ids.push_back(0);
            ack_cycles.push_back(cycle);
            ack_cnt0++;
            check_output("m1_quiet_on_m0_ack", m1_rdata | {30'b0, m1_ack, m1_err}, 32'h0);
            if (q0.size() == 0) begin
                flag_unexpected("m0_unexpected_ack");
            end else begin
                e = q0.pop_front();
                check_output("m0_rdata", m0_rdata, e.rdata);
                check_output("m0_err", {31'b0, m0_err}, {31'b0, e.err});
            end
        end
        if (m1_ack) begin
            ack_ids.push_back(1);
            ack_cycles.push_back(cycle);
            ack_cnt1++;
            check_output("m0_quiet_on_m1_ack", m0_rdata | {30'b0, m0_ack, m0_err}, 32'h0);
            if (q1.size() == 0) begin
                flag_unexpected("m1_unexpected_ack");
            end else begin
                e = q1.pop_front();
                check_output("m1_rdata", m1_rdata, e.rdata);
                check_output("m1_err", {31'b0, m1_err}, {31'b0, e.err});
            end
        end
    end

    // Issues one access, queues its expected response and waits (bounded) for the ack.
    task automatic apply_stimulus(input int master, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                  input logic exp_err);
        exp_t e;
        int   start;
        logic got;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        @(negedge clk);
        if (master == 0) begin
            q0.push_back(e);
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end else begin
            q1.push_back(e);
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end
        start = cycle;
        got   = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = (master == 0) ? m0_ack : m1_ack;
        end
        check_output("ack_seen", {31'b0, got}, 32'h1);
        if (got) check_output("ack_latency", 32'(cycle - start), 32'd2);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int wr_before, rd_before, acks_before;
        rst_n  = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4; m1_wdata = 32'h0;

        // Reset with both masters requesting, then saturated alternating reads.
        repeat (3) @(negedge clk);
        check_output("reset_acks", {30'b0, m0_ack, m1_ack}, 32'h0);
        check_output("reset_strobes", {30'b0, mem_read, mem_write}, 32'h0);
        check_output("reset_mem_addr", mem_addr | mem_wdata, 32'h0);
        check_output("reset_rdata", m0_rdata | m1_rdata | {30'b0, m0_err, m1_err}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            q0.push_back('{rdata: 32'h1000_0000, err: 1'b0});
            q1.push_back('{rdata: 32'h1000_0001, err: 1'b0});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40 && (ack_cnt0 + ack_cnt1) < 6; i++) begin
            @(negedge clk);
            #1;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check_output("saturated_ack_total", 32'(ack_cnt0 + ack_cnt1), 32'd6);
        if (ack_ids.size() >= 6) begin
            for (int i = 0; i < 6; i++) check_output("ack_order", 32'(ack_ids[i]), 32'(i % 2));
            for (int i = 0; i < 5; i++)
                check_output("ack_spacing", 32'(ack_cycles[i+1] - ack_cycles[i]), 32'd2);
        end
        repeat (3) @(negedge clk);

        // Write then read back through master 0.
        wr_before = wr_cnt;
        apply_stimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        check_output("write_strobe_count", 32'(wr_cnt - wr_before), 32'd1);
        check_output("write_addr", last_wr_addr, 32'h10);
        check_output("write_data", last_wr_data, 32'hDEADBEEF);
        check_output("mem_word4", mem_model[4], 32'hDEADBEEF);
        apply_stimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        check_output("idle_mem_bus", mem_addr | mem_wdata | {30'b0, mem_read, mem_write}, 32'h0);

        // Misaligned write from master 1.
        wr_before = wr_cnt;
        apply_stimulus(1, 1'b1, 32'h6, 32'h1234_5678, 32'h0, 1'b1);
        check_output("misaligned_no_write", 32'(wr_cnt - wr_before), 32'd0);
        check_output("mem_word1_intact", mem_model[1], 32'h1000_0001);

        // Range boundary: word 256 is out of range, word 255 is the last valid one.
        rd_before = rd_cnt;
        apply_stimulus(0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
        check_output("oob_no_read", 32'(rd_cnt - rd_before), 32'd0);
        rd_before = rd_cnt;
        apply_stimulus(0, 1'b0, 32'h3FC, 32'h0, 32'h1000_00FF, 1'b0);
        check_output("last_word_read", 32'(rd_cnt - rd_before), 32'd1);

        // Reset asserted in the middle of a write's ACCESS cycle.
        wr_before   = wr_cnt;
        acks_before = ack_cnt0;
        @(negedge clk);
        m0_we = 1'b1; m0_addr = 32'h8; m0_wdata = 32'h55; m0_req = 1'b1;
        @(posedge clk);
        #2;
        check_output("access_write_strobe", {31'b0, mem_write}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_output("abort_strobe_drop", {31'b0, mem_write}, 32'h0);
        @(negedge clk);
        m0_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_output("abort_word2", mem_model[2], 32'h1000_0002);
        check_output("abort_no_ack", 32'(ack_cnt0 - acks_before), 32'd0);
        check_output("abort_no_write", 32'(wr_cnt - wr_before), 32'd0);

        check_output("q0_drained", 32'(q0.size()), 32'd0);
        check_output("q1_drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
